hazard_scoreboard: RTL and testbench

- Parametrised successor to the D-stage stall unit of the pipelined MIPS core.
- Replaces per-stage decoder copies with an internal in-flight scoreboard: NSTAGE entries, each holding destination and remaining Tnew. Tnew counts down as entries advance.
- Adds a cycle-accurate mult/div busy counter and optional stall statistics.
- Sits beside the D/E pipeline register; its stall output freezes PC/FD and bubbles E.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/md_busy_ctr.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared widths, scoreboard entry record and Tnew helper for the
//               D-stage hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int REG_AW       = 5;
    localparam int TW           = 3;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // A Tuse of all-ones marks an operand that the instruction never reads.
    localparam logic [TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [TW-1:0]     tnew;
        logic              md;
    } entry_t;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? v : v - TW'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_ctr.sv
// ============================================================================
// Module      : md_busy_ctr
// Description : Mult/div unit busy counter. Loads the operation latency and
//               counts down to zero every cycle, regardless of pipeline freeze.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CW       = $clog2(DIV_CYC + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_div,
    output logic          o_busy,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] C_MULT = CW'(MULT_CYC);
    localparam logic [CW-1:0] C_DIV  = CW'(DIV_CYC);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_div ? C_DIV : C_MULT;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_busy  = (count_q != '0);
    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : D-stage stall unit built on an in-flight producer scoreboard
//               plus a mult/div busy counter. Optional stall statistics are
//               enabled with the HAZARD_STAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int TW       = hazard_pkg::TW,
    parameter int NSTAGE   = 3,
    parameter int MULT_CYC = hazard_pkg::MULT_CYC_DEF,
    parameter int DIV_CYC  = hazard_pkg::DIV_CYC_DEF,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TW-1:0]     d_rs_use,
    input  logic [TW-1:0]     d_rt_use,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_acc,
    output logic              stall,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  md_stall_cnt
);

    import hazard_pkg::*;

    localparam int C_MD_W = $clog2(DIV_CYC + 1);

    entry_t entry_q [NSTAGE];
    entry_t entry_d [NSTAGE];

    logic              w_hit_rs;
    logic              w_hit_rt;
    logic              w_haz_rs;
    logic              w_haz_rt;
    logic              w_mdu_haz;
    logic              w_md_load;
    logic [C_MD_W-1:0] w_md_count;
    logic              w_unused;

    // Youngest matching producer wins; older matches for the same register are masked.
    always_comb begin
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        w_haz_rs = 1'b0;
        w_haz_rt = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!w_hit_rs && entry_q[i].valid && (d_rs != '0) && (entry_q[i].dst == d_rs)) begin
                w_hit_rs = 1'b1;
                w_haz_rs = (d_rs_use != TUSE_NONE) && (entry_q[i].tnew > d_rs_use);
            end
            if (!w_hit_rt && entry_q[i].valid && (d_rt != '0) && (entry_q[i].dst == d_rt)) begin
                w_hit_rt = 1'b1;
                w_haz_rt = (d_rt_use != TUSE_NONE) && (entry_q[i].tnew > d_rt_use);
            end
        end
    end

    assign w_mdu_haz = (d_md_start | d_md_acc) & md_busy;
    assign stall     = w_haz_rs | w_haz_rt | w_mdu_haz;
    assign w_md_load = adv & ~stall & d_md_start;

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            entry_d[k] = entry_q[k];
        end
        if (adv) begin
            for (int k = 1; k < NSTAGE; k++) begin
                entry_d[k]      = entry_q[k-1];
                entry_d[k].tnew = sat_dec(entry_q[k-1].tnew);
            end
            if (stall) begin
                entry_d[0] = '0;
            end else begin
                entry_d[0].valid = 1'b1;
                entry_d[0].dst   = d_dst;
                entry_d[0].tnew  = d_tnew;
                entry_d[0].md    = d_md_start;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                entry_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                entry_q[k] <= entry_d[k];
            end
        end
    end

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CW       (C_MD_W)
    ) u_md_busy_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_md_load),
        .i_div   (d_md_div),
        .o_busy  (md_busy),
        .o_count (w_md_count)
    );

    // The md tag and raw count are kept for debug visibility only.
    assign w_unused = ^{entry_q[NSTAGE-1].md, w_md_count};

`ifdef HAZARD_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] md_stall_cnt_q;
    logic [CNT_W-1:0] md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;
        if (adv && stall) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (w_mdu_haz && (md_stall_cnt_q != '1)) begin
                md_stall_cnt_d = md_stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`else
    assign stall_cnt    = '0;
    assign md_stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard; stat
//               counter expectations follow the HAZARD_STAT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int REG_AW   = 5;
    localparam int TW       = 3;
    localparam int NSTAGE   = 3;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int CNT_W    = 32;
    localparam logic [TW-1:0] NONE = '1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              adv = 1'b1;
    logic [REG_AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0]     d_rs_use, d_rt_use, d_tnew;
    logic              d_md_start, d_md_div, d_md_acc;
    logic              stall, md_busy;
    logic [CNT_W-1:0]  stall_cnt, md_stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_sc = '0;
    logic [CNT_W-1:0] exp_mc = '0;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .TW(TW), .NSTAGE(NSTAGE),
        .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .adv(adv),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use), .d_rt_use(d_rt_use),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_acc(d_md_acc),
        .stall(stall), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = '0; d_rt = '0; d_rs_use = NONE; d_rt_use = NONE;
        d_dst = '0; d_tnew = '0;
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_acc = 1'b0;
    endtask

    task automatic issue(input logic [REG_AW-1:0] dst, input logic [TW-1:0] tnew);
        idle();
        d_dst = dst; d_tnew = tnew;
    endtask

    task automatic test_reset();
        reset = 1'b0; adv = 1'b1;
        idle(); d_md_acc = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy: got %0d want 0", md_busy); end
        n_vec++; if (stall_cnt !== '0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_vec++; if (md_stall_cnt !== '0) begin n_err++; $display("FAIL reset_md_stall_cnt: got %0d want 0", md_stall_cnt); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL post_reset_stall: got %0d want 0", stall); end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        logic exp;
        issue(5'd8, 3'd2);
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lw_issue: got %0d want 0", stall); end
        tick();
        issue(5'd9, 3'd1); d_rs = 5'd8; d_rs_use = 3'd0;
        for (int i = 0; i < 3; i++) begin
            exp = (i < 2);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL lw_use0 cyc%0d: got %0d want %0d", i, stall, exp); end
            if (exp) exp_sc++;
            tick();
        end
        idle(); repeat (NSTAGE) tick();
        issue(5'd8, 3'd2); tick();
        issue(5'd9, 3'd1); d_rt = 5'd8; d_rt_use = 3'd1;
        for (int i = 0; i < 2; i++) begin
            exp = (i < 1);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL lw_use1_rt cyc%0d: got %0d want %0d", i, stall, exp); end
            if (exp) exp_sc++;
            tick();
        end
        idle(); repeat (NSTAGE) tick();
    endtask

    task automatic test_youngest();
        logic exp;
        issue(5'd8, 3'd1); tick();
        issue(5'd8, 3'd2); tick();
        idle(); d_rs = 5'd8; d_rs_use = 3'd0;
        for (int i = 0; i < 3; i++) begin
            exp = (i < 2);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL youngest_lw cyc%0d: got %0d want %0d", i, stall, exp); end
            if (exp) exp_sc++;
            tick();
        end
        idle(); repeat (NSTAGE) tick();
        // Younger producer with Tnew 0 must mask the older load still at Tnew 1.
        issue(5'd8, 3'd2); tick();
        issue(5'd8, 3'd0); tick();
        idle(); d_rs = 5'd8; d_rs_use = 3'd0;
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL youngest_mask: got %0d want 0", stall); end
        tick();
        idle(); repeat (NSTAGE) tick();
    endtask

    task automatic test_zero_reg();
        issue(5'd0, 3'd2); tick();
        idle(); d_rs = 5'd0; d_rs_use = 3'd0; d_rt = 5'd0; d_rt_use = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_reg cyc%0d: got %0d want 0", i, stall); end
            tick();
        end
        idle(); repeat (NSTAGE) tick();
    endtask

    task automatic test_freeze_reg();
        logic exp;
        issue(5'd8, 3'd2); tick();
        idle(); d_rs = 5'd8; d_rs_use = 3'd0;
        for (int i = 0; i < 5; i++) begin
            adv = !(i == 1 || i == 2);
            exp = (i < 4);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL freeze_reg cyc%0d: got %0d want %0d", i, stall, exp); end
            if (exp && adv) exp_sc++;
            tick();
        end
        adv = 1'b1;
        idle(); repeat (NSTAGE) tick();
    endtask

    task automatic test_mdu(input logic div, input int n);
        logic exp;
        idle(); d_md_start = 1'b1; d_md_div = div;
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL md_issue div%0d: got %0d want 0", div, stall); end
        tick();
        issue(5'd9, 3'd1); d_md_acc = 1'b1;
        for (int i = 0; i <= n; i++) begin
            exp = (i < n);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL mflo_div%0d cyc%0d: got %0d want %0d", div, i, stall, exp); end
            n_vec++; if (md_busy !== exp) begin n_err++; $display("FAIL md_busy_div%0d cyc%0d: got %0d want %0d", div, i, md_busy, exp); end
            if (exp) begin exp_sc++; exp_mc++; end
            tick();
        end
        idle(); repeat (NSTAGE) tick();
    endtask

    task automatic test_back_to_back();
        logic exp;
        idle(); d_md_start = 1'b1; tick();
        for (int i = 0; i <= MULT_CYC; i++) begin
            exp = (i < MULT_CYC);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL b2b_mult cyc%0d: got %0d want %0d", i, stall, exp); end
            if (exp) begin exp_sc++; exp_mc++; end
            tick();
        end
        idle();
        @(negedge clk);
        n_vec++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL b2b_reload: got %0d want 1", md_busy); end
        repeat (MULT_CYC) tick();
        @(negedge clk);
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0d want 0", md_busy); end
        tick();
    endtask

    task automatic test_mdu_freeze();
        logic exp;
        idle(); d_md_start = 1'b1; d_md_div = 1'b1; tick();
        issue(5'd9, 3'd1); d_md_acc = 1'b1;
        for (int j = 0; j <= DIV_CYC; j++) begin
            adv = !(j >= 2 && j <= 4);
            exp = (j < DIV_CYC);
            @(negedge clk);
            n_vec++; if (stall !== exp) begin n_err++; $display("FAIL mdfrz_stall cyc%0d: got %0d want %0d", j, stall, exp); end
            n_vec++; if (md_busy !== exp) begin n_err++; $display("FAIL mdfrz_busy cyc%0d: got %0d want %0d", j, md_busy, exp); end
            if (exp && adv) begin exp_sc++; exp_mc++; end
            tick();
        end
        adv = 1'b1;
        idle(); tick();
        @(negedge clk);
`ifdef HAZARD_STAT_EN
        n_vec++; if (stall_cnt !== exp_sc) begin n_err++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_sc); end
        n_vec++; if (md_stall_cnt !== exp_mc) begin n_err++; $display("FAIL md_stall_cnt: got %0d want %0d", md_stall_cnt, exp_mc); end
`else
        n_vec++; if (stall_cnt !== '0) begin n_err++; $display("FAIL stall_cnt_off: got %0d want 0", stall_cnt); end
        n_vec++; if (md_stall_cnt !== '0) begin n_err++; $display("FAIL md_stall_cnt_off: got %0d want 0", md_stall_cnt); end
`endif
        tick();
    endtask

    task automatic test_reset_mid_stall();
        issue(5'd8, 3'd2); tick();
        idle(); d_rs = 5'd8; d_rs_use = 3'd0;
        @(negedge clk);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %0d want 1", stall); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_async: got %0d want 0", stall); end
        n_vec++; if (stall_cnt !== '0) begin n_err++; $display("FAIL mid_stall_cnt: got %0d want 0", stall_cnt); end
        tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_after: got %0d want 0", stall); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mid_md_busy: got %0d want 0", md_busy); end
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_youngest();
        test_zero_reg();
        test_freeze_reg();
        test_mdu(1'b1, DIV_CYC);
        test_mdu(1'b0, MULT_CYC);
        test_back_to_back();
        test_mdu_freeze();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
